// File: rtl/cache_ctrl_pkg.sv
// Shared types, widths and helpers for the direct-mapped write-through cache controller.
package cache_ctrl_pkg;

  localparam int unsigned ADDR_WIDTH      = 10;
  localparam int unsigned DATA_WIDTH      = 16;
  localparam int unsigned INDEX_WIDTH     = 4;
  localparam int unsigned DEF_MEM_LATENCY = 2;
  localparam int unsigned CNT_WIDTH       = 4;
  localparam int unsigned STAT_WIDTH      = 16;

  function automatic int unsigned tag_width(input int unsigned aw, input int unsigned iw);
    return aw - iw;
  endfunction

  function automatic int unsigned line_count(input int unsigned iw);
    return 32'd1 << iw;
  endfunction

  localparam int unsigned TAG_WIDTH = tag_width(ADDR_WIDTH, INDEX_WIDTH);
  localparam int unsigned LINES     = line_count(INDEX_WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    MEM_RD,
    FILL,
    WR_THRU
  } state_t;

  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

endpackage

// File: rtl/cache_line_store.sv
// Tag/valid/data arrays: combinational read by index, synchronous single write port.
module cache_line_store
  import cache_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [INDEX_WIDTH-1:0] rd_index,
  output logic                   rd_valid_c,
  output logic [TAG_WIDTH-1:0]   rd_tag_c,
  output logic [DATA_WIDTH-1:0]  rd_data_c,
  input  logic                   wr_en,
  input  logic [INDEX_WIDTH-1:0] wr_index,
  input  logic [TAG_WIDTH-1:0]   wr_tag,
  input  logic [DATA_WIDTH-1:0]  wr_data
);

  logic [LINES-1:0]      valid;
  logic [TAG_WIDTH-1:0]  tags [LINES];
  logic [DATA_WIDTH-1:0] data [LINES];

  // Only valid bits need reset; tag/data are qualified by valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[wr_index] <= wr_tag;
      data[wr_index] <= wr_data;
    end
  end

  assign rd_valid_c = valid[rd_index];
  assign rd_tag_c   = tags[rd_index];
  assign rd_data_c  = data[rd_index];

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped write-through cache controller with single outstanding request.
// Optional hit/miss counters enabled by defining CACHE_CTRL_STATS_EN.
module cache_ctrl
  import cache_ctrl_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = DEF_MEM_LATENCY
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_we,
  output logic                  mem_oe
`ifdef CACHE_CTRL_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0] stat_hits,
  output logic [STAT_WIDTH-1:0] stat_misses
`endif
);

  state_t                state;
  req_t                  req;
  logic [CNT_WIDTH-1:0]  cnt;
  logic [DATA_WIDTH-1:0] fill_data;

  logic                   rd_valid_c;
  logic [TAG_WIDTH-1:0]   rd_tag_c;
  logic [DATA_WIDTH-1:0]  rd_data_c;
  logic [INDEX_WIDTH-1:0] index_c;
  logic [TAG_WIDTH-1:0]   tag_c;
  logic                   hit_c;
  logic                   line_we_c;
  logic [DATA_WIDTH-1:0]  line_wdata_c;

  assign index_c = req.addr[INDEX_WIDTH-1:0];
  assign tag_c   = req.addr[ADDR_WIDTH-1:INDEX_WIDTH];
  assign hit_c   = rd_valid_c && (rd_tag_c == tag_c);

  // Fills always allocate; stores only refresh a line they already hit.
  assign line_we_c    = (state == FILL) || ((state == WR_THRU) && hit_c);
  assign line_wdata_c = (state == FILL) ? fill_data : req.wdata;

  cache_line_store u_store (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_index   (index_c),
    .rd_valid_c (rd_valid_c),
    .rd_tag_c   (rd_tag_c),
    .rd_data_c  (rd_data_c),
    .wr_en      (line_we_c),
    .wr_index   (index_c),
    .wr_tag     (tag_c),
    .wr_data    (line_wdata_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      req        <= '0;
      cnt        <= '0;
      fill_data  <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      mem_oe     <= 1'b0;
`ifdef CACHE_CTRL_STATS_EN
      stat_hits   <= '0;
      stat_misses <= '0;
`endif
    end else begin
      resp_valid <= 1'b0;
      mem_we     <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            req       <= '{write: req_write, addr: req_addr, wdata: req_wdata};
            req_ready <= 1'b0;
            state     <= COMPARE;
          end
        end
        COMPARE: begin
`ifdef CACHE_CTRL_STATS_EN
          if (hit_c) begin
            if (stat_hits != '1) stat_hits <= stat_hits + STAT_WIDTH'(1);
          end else begin
            if (stat_misses != '1) stat_misses <= stat_misses + STAT_WIDTH'(1);
          end
`endif
          if (req.write) begin
            // Write strobe and completion pulse are issued together.
            mem_we     <= 1'b1;
            mem_addr   <= req.addr;
            mem_wdata  <= req.wdata;
            resp_valid <= 1'b1;
            state      <= WR_THRU;
          end else if (hit_c) begin
            resp_valid <= 1'b1;
            resp_rdata <= rd_data_c;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end else begin
            cnt   <= CNT_WIDTH'(MEM_LATENCY - 1);
            state <= MEM_RD;
          end
        end
        MEM_RD: begin
          // First cycle raises mem_oe; then count down the memory latency.
          if (!mem_oe) begin
            mem_oe   <= 1'b1;
            mem_addr <= req.addr;
          end else if (cnt == '0) begin
            fill_data <= mem_rdata;
            mem_oe    <= 1'b0;
            state     <= FILL;
          end else begin
            cnt <= cnt - CNT_WIDTH'(1);
          end
        end
        FILL: begin
          resp_valid <= 1'b1;
          resp_rdata <= fill_data;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        WR_THRU: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Randomized self-checking bench for cache_ctrl against a direct-mapped reference model.
module tb_cache_ctrl;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [9:0]  req_addr;
  logic [15:0] req_wdata;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic [9:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_we;
  logic        mem_oe;
`ifdef CACHE_CTRL_STATS_EN
  logic [15:0] stat_hits;
  logic [15:0] stat_misses;
`endif

  always #5 clk = ~clk;

  cache_ctrl #(.MEM_LATENCY(LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_we     (mem_we),
    .mem_oe     (mem_oe)
`ifdef CACHE_CTRL_STATS_EN
    ,
    .stat_hits  (stat_hits),
    .stat_misses(stat_misses)
`endif
  );

  // Memory: read data becomes valid only after mem_oe has been high LAT cycles.
  logic [15:0] mem [1024];
  int          oe_age = 0;
  always @(posedge clk) oe_age <= mem_oe ? oe_age + 1 : 0;
  assign mem_rdata = (mem_oe && oe_age >= LAT - 1) ? mem[mem_addr] : 16'hDEAD;

  // Reference model: what memory should hold, and which address each line holds.
  logic [15:0] ref_mem [1024];
  logic [9:0]  m_addr [16];
  logic [15:0] m_valid;
  logic [15:0] last_rdata;
  int          exp_hits;
  int          exp_misses;
  int          n_checks;
  int          n_errors;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_req(input logic wr, input logic [9:0] addr, input logic [15:0] wdata);
    int   idx;
    logic exp_hit;
    int   exp_lat;
    int   n;
    int   lat;
    int   oe_n;
    int   we_n;
    idx     = int'(addr[3:0]);
    exp_hit = m_valid[idx] && (m_addr[idx] == addr);
    exp_lat = (wr || exp_hit) ? 1 : LAT + 3;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = 10'($urandom);
    req_wdata = 16'($urandom);
    check("busy_not_ready", 32'(req_ready), 32'd0);
    lat  = 0;
    oe_n = 0;
    we_n = 0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(posedge clk);
      #1;
      if (mem_oe || mem_we) check("oe_we_excl", 32'(mem_oe && mem_we), 32'd0);
      if (mem_oe) begin
        oe_n++;
        check("oe_addr", 32'(mem_addr), 32'(addr));
      end
      if (mem_we) begin
        we_n++;
        check("we_addr", 32'(mem_addr), 32'(addr));
        check("we_data", 32'(mem_wdata), 32'(wdata));
        mem[mem_addr] = mem_wdata;
      end
      if (resp_valid) lat = k;
    end
    check("resp_seen", 32'(lat != 0), 32'd1);
    check("latency", 32'(lat), 32'(exp_lat));
    check("oe_cycles", 32'(oe_n), (!wr && !exp_hit) ? 32'(LAT) : 32'd0);
    check("we_cycles", 32'(we_n), wr ? 32'd1 : 32'd0);
    if (wr) begin
      check("rdata_hold", 32'(resp_rdata), 32'(last_rdata));
      ref_mem[addr] = wdata;
    end else begin
      check("rdata", 32'(resp_rdata), 32'(ref_mem[addr]));
      last_rdata   = ref_mem[addr];
      m_valid[idx] = 1'b1;
      m_addr[idx]  = addr;
    end
    if (exp_hit) exp_hits++;
    else exp_misses++;
    @(posedge clk);
    #1;
    check("resp_pulse", 32'(resp_valid), 32'd0);
  endtask

  task automatic check_stats();
`ifdef CACHE_CTRL_STATS_EN
    check("stat_hits", 32'(stat_hits), 32'(exp_hits));
    check("stat_misses", 32'(stat_misses), 32'(exp_misses));
`endif
  endtask

  initial begin
    logic [9:0] ra;
    int         n;
    n_checks   = 0;
    n_errors   = 0;
    exp_hits   = 0;
    exp_misses = 0;
    m_valid    = '0;
    last_rdata = '0;
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = 16'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[10'h012] = 16'hBEEF; ref_mem[10'h012] = 16'hBEEF;
    mem[10'h022] = 16'h5555; ref_mem[10'h022] = 16'h5555;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_oe", 32'(mem_oe), 32'd0);
    check("rst_resp_rdata", 32'(resp_rdata), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check_stats();
    @(negedge clk);
    rst_n = 1'b1;

    // Directed sequence: miss fill, hit, store hit, aliasing, no-allocate store.
    do_req(1'b0, 10'h012, 16'h0);
    check("first_fill_beef", 32'(resp_rdata), 32'h0000BEEF);
    do_req(1'b0, 10'h012, 16'h0);
    do_req(1'b1, 10'h012, 16'h1234);
    do_req(1'b0, 10'h012, 16'h0);
    check("store_hit_data", 32'(resp_rdata), 32'h00001234);
    do_req(1'b0, 10'h022, 16'h0);
    check("alias_fill", 32'(resp_rdata), 32'h00005555);
    do_req(1'b0, 10'h012, 16'h0);
    do_req(1'b1, 10'h3FF, 16'hA5A5);
    do_req(1'b0, 10'h3FF, 16'h0);
    check_stats();

    // Reset while a miss is reading memory.
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 10'h155;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    n = 0;
    while (!mem_oe && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("rst_mid_oe_seen", 32'(mem_oe), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_oe_drop", 32'(mem_oe), 32'd0);
    check("rst_mid_no_resp", 32'(resp_valid), 32'd0);
    check("rst_mid_ready", 32'(req_ready), 32'd1);
    repeat (3) @(negedge clk);
    check("rst_mid_still_no_resp", 32'(resp_valid), 32'd0);
    rst_n      = 1'b1;
    m_valid    = '0;
    exp_hits   = 0;
    exp_misses = 0;
    last_rdata = '0;
    check_stats();
    do_req(1'b0, 10'h012, 16'h0);

    // Random mix over a small address pool so hits, misses and aliasing all occur.
    for (int t = 0; t < 150; t++) begin
      ra = 10'($urandom_range(0, 3) * 16 + $urandom_range(0, 15));
      do_req(($urandom_range(0, 2) == 0), ra, 16'($urandom));
    end
    check_stats();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
